// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
//
// Purpose:
//   Hazard detection and forwarding control for the pipelined core.
//   - Compares every source operand of the instruction in R against the
//     destinations of the downstream write stages (index 0 = C, youngest)
//     and registers a per-operand forward select for use in C.
//   - Detects load-use hazards and requests a PC/IR stall plus a C bubble.
//   - Tracks one in-flight long-latency (mul/div) operation in a single-entry
//     scoreboard: stalls RAW, WAW and structural hazards against it and
//     forwards its result in the cycle it completes.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   srcAdr_R     source register addresses in R (operand i at [i*ADR_W +: ADR_W])
//   srcUsed_R    operand i is actually read
//   rdAdr_R      destination of the instruction in R
//   RegWrite_R   instruction in R writes rdAdr_R
//   LongReq_R    instruction in R needs the long-latency unit
//   fwdAdr       destination address per forwarding stage
//   fwdWrite     stage writes its destination
//   fwdLoad      stage holds a load
//   LongIssue_C  long op leaves C this cycle (destination = fwdAdr stage 0)
//   FwdSel_C     registered select per operand: 0 none, k stage k-1,
//                NUM_FWD+1 long-unit result
//   LongDone     one-cycle pulse, long result valid / written this cycle
//   LongBusy     long unit occupied
//   StallPC      hold PC
//   StallIR      hold IR
//   FlushRC      insert bubble into C
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit #(
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 2,
  parameter int LOAD_RDY = 1,
  parameter int LONG_LAT = 8,
  parameter int ADR_W    = 5,
  parameter int FSEL_W   = $clog2(NUM_FWD + 2)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*ADR_W-1:0]  srcAdr_R,
  input  logic [NUM_SRC-1:0]        srcUsed_R,
  input  logic [ADR_W-1:0]          rdAdr_R,
  input  logic                      RegWrite_R,
  input  logic                      LongReq_R,
  input  logic [NUM_FWD*ADR_W-1:0]  fwdAdr,
  input  logic [NUM_FWD-1:0]        fwdWrite,
  input  logic [NUM_FWD-1:0]        fwdLoad,
  input  logic                      LongIssue_C,
  output logic [NUM_SRC*FSEL_W-1:0] FwdSel_C,
  output logic                      LongDone,
  output logic                      LongBusy,
  output logic                      StallPC,
  output logic                      StallIR,
  output logic                      FlushRC
);

  localparam int CNT_W = $clog2(LONG_LAT);
  localparam logic [FSEL_W-1:0] SEL_LONG = FSEL_W'(NUM_FWD + 1);

  // Scoreboard / output registers
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      pend_valid_q, pend_valid_d;
  logic [ADR_W-1:0]          pend_adr_q, pend_adr_d;
  logic [NUM_SRC*FSEL_W-1:0] fwd_sel_q, fwd_sel_d;

  // Combinational hazard terms
  logic [NUM_FWD-1:0]        smatch_s [NUM_SRC];
  logic [NUM_SRC*FSEL_W-1:0] stage_sel_s;
  logic [NUM_SRC-1:0]        hit_s;
  logic [NUM_SRC-1:0]        ld_s;
  logic [NUM_SRC-1:0]        lmatch_s;
  logic [NUM_SRC*FSEL_W-1:0] sel_s;
  logic                      load_use_s;
  logic                      raw_s;
  logic                      waw_s;
  logic                      struct_s;
  logic                      stall_s;

  // Per operand / per stage address match; register 0 never matches.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      smatch_s[i] = '0;
      for (int k = 0; k < NUM_FWD; k++) begin
        smatch_s[i][k] = srcUsed_R[i] && fwdWrite[k] &&
                         (fwdAdr[k*ADR_W +: ADR_W] != '0) &&
                         (srcAdr_R[i*ADR_W +: ADR_W] == fwdAdr[k*ADR_W +: ADR_W]);
      end
    end
  end

  // Priority pick per operand: walk oldest to youngest so the youngest match
  // (lowest stage index) is the one left standing.
  always_comb begin
    stage_sel_s = '0;
    hit_s       = '0;
    ld_s        = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        stage_sel_s[i*FSEL_W +: FSEL_W] = smatch_s[i][k] ? FSEL_W'(k + 1)
                                                          : stage_sel_s[i*FSEL_W +: FSEL_W];
        ld_s[i]  = smatch_s[i][k] ? (fwdLoad[k] && (k < LOAD_RDY)) : ld_s[i];
        hit_s[i] = hit_s[i] | smatch_s[i][k];
      end
    end
  end

  // Hazard combination and next forward select.
  // The pending entry no longer blocks in its done cycle: its result is
  // forwarded instead, but only when no pipeline stage already supplies it.
  always_comb begin
    sel_s      = '0;
    load_use_s = 1'b0;
    raw_s      = 1'b0;
    lmatch_s   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      lmatch_s[i] = srcUsed_R[i] && pend_valid_q &&
                    (srcAdr_R[i*ADR_W +: ADR_W] == pend_adr_q);
      load_use_s  = load_use_s | (hit_s[i] & ld_s[i]);
      raw_s       = raw_s | (lmatch_s[i] & ~done_q);
      sel_s[i*FSEL_W +: FSEL_W] = hit_s[i] ? stage_sel_s[i*FSEL_W +: FSEL_W] :
                                  ((lmatch_s[i] && done_q) ? SEL_LONG : FSEL_W'(0));
    end
    waw_s    = RegWrite_R && pend_valid_q && !done_q &&
               (rdAdr_R == pend_adr_q) && (rdAdr_R != '0);
    struct_s = LongReq_R && busy_q && !done_q;
    stall_s  = load_use_s | raw_s | waw_s | struct_s;
    fwd_sel_d = stall_s ? '0 : sel_s;
  end

  // Long-unit scoreboard next state. An issue is taken when idle or in the
  // done cycle (new entry replaces the retiring one); an issue while busy is
  // ignored. Busy/pending clear at the end of the done cycle.
  always_comb begin
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    pend_valid_d = pend_valid_q;
    pend_adr_d   = pend_adr_q;
    done_d       = 1'b0;
    if (LongIssue_C && (!busy_q || done_q)) begin
      cnt_d        = CNT_W'(LONG_LAT - 1);
      busy_d       = 1'b1;
      pend_valid_d = (fwdAdr[ADR_W-1:0] != '0);
      pend_adr_d   = fwdAdr[ADR_W-1:0];
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end else if (done_q) begin
      busy_d       = 1'b0;
      pend_valid_d = 1'b0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_adr_q   <= '0;
      fwd_sel_q    <= '0;
    end else begin
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pend_valid_q <= pend_valid_d;
      pend_adr_q   <= pend_adr_d;
      fwd_sel_q    <= fwd_sel_d;
    end
  end

  assign FwdSel_C = fwd_sel_q;
  assign LongDone = done_q;
  assign LongBusy = busy_q;
  assign StallPC  = stall_s;
  assign StallIR  = stall_s;
  assign FlushRC  = stall_s;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// Testbench for hazard_scoreboard_unit: directed scenarios plus randomized
// traffic checked against a cycle-count based reference model.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;

  localparam int NUM_SRC  = 2;
  localparam int NUM_FWD  = 2;
  localparam int LOAD_RDY = 1;
  localparam int LONG_LAT = 8;
  localparam int ADR_W    = 5;
  localparam int FSEL_W   = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_SRC*ADR_W-1:0]  srcAdr_R;
  logic [NUM_SRC-1:0]        srcUsed_R;
  logic [ADR_W-1:0]          rdAdr_R;
  logic                      RegWrite_R;
  logic                      LongReq_R;
  logic [NUM_FWD*ADR_W-1:0]  fwdAdr;
  logic [NUM_FWD-1:0]        fwdWrite;
  logic [NUM_FWD-1:0]        fwdLoad;
  logic                      LongIssue_C;
  logic [NUM_SRC*FSEL_W-1:0] FwdSel_C;
  logic                      LongDone;
  logic                      LongBusy;
  logic                      StallPC;
  logic                      StallIR;
  logic                      FlushRC;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: the long op is described by its issue cycle; its age
  // (cycles since issue) decides busy/done.
  int                        cyc     = 0;
  bit                        m_valid = 1'b0;
  int                        m_t0    = 0;
  logic [ADR_W-1:0]          m_dest  = '0;
  logic [NUM_SRC*FSEL_W-1:0] m_sel   = '0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(
    .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .LOAD_RDY(LOAD_RDY),
    .LONG_LAT(LONG_LAT), .ADR_W(ADR_W), .FSEL_W(FSEL_W)
  ) dut (
    .clk(clk), .reset(reset), .srcAdr_R(srcAdr_R), .srcUsed_R(srcUsed_R),
    .rdAdr_R(rdAdr_R), .RegWrite_R(RegWrite_R), .LongReq_R(LongReq_R),
    .fwdAdr(fwdAdr), .fwdWrite(fwdWrite), .fwdLoad(fwdLoad),
    .LongIssue_C(LongIssue_C), .FwdSel_C(FwdSel_C), .LongDone(LongDone),
    .LongBusy(LongBusy), .StallPC(StallPC), .StallIR(StallIR), .FlushRC(FlushRC)
  );

  function automatic logic [ADR_W-1:0] src_of(int i);
    return srcAdr_R[i*ADR_W +: ADR_W];
  endfunction

  function automatic logic [ADR_W-1:0] fadr(int k);
    return fwdAdr[k*ADR_W +: ADR_W];
  endfunction

  function automatic bit m_done();
    return m_valid && ((cyc - m_t0) == LONG_LAT);
  endfunction

  function automatic bit m_pend();
    return m_valid && (m_dest != '0);
  endfunction

  // Youngest stage supplying operand i, or -1.
  function automatic int m_winner(int i);
    for (int k = 0; k < NUM_FWD; k++)
      if (srcUsed_R[i] && fwdWrite[k] && fadr(k) != '0 && src_of(i) == fadr(k)) return k;
    return -1;
  endfunction

  function automatic bit m_stall();
    bit s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int w = m_winner(i);
      if (w >= 0 && fwdLoad[w] && w < LOAD_RDY) s = 1'b1;
      if (srcUsed_R[i] && m_pend() && !m_done() && src_of(i) == m_dest) s = 1'b1;
    end
    if (RegWrite_R && m_pend() && !m_done() && rdAdr_R == m_dest) s = 1'b1;
    if (LongReq_R && m_valid && !m_done()) s = 1'b1;
    return s;
  endfunction

  function automatic logic [NUM_SRC*FSEL_W-1:0] m_next_sel();
    logic [NUM_SRC*FSEL_W-1:0] r = '0;
    if (m_stall()) return r;
    for (int i = 0; i < NUM_SRC; i++) begin
      int w = m_winner(i);
      if (w >= 0) r[i*FSEL_W +: FSEL_W] = FSEL_W'(w + 1);
      else if (m_done() && m_pend() && srcUsed_R[i] && src_of(i) == m_dest)
        r[i*FSEL_W +: FSEL_W] = FSEL_W'(NUM_FWD + 1);
    end
    return r;
  endfunction

  // Advance one clock; the model updates from the inputs seen at the edge.
  task automatic tick();
    logic [NUM_SRC*FSEL_W-1:0] nsel;
    bit                        acc;
    logic [ADR_W-1:0]          nd;
    nsel = reset ? '0 : m_next_sel();
    acc  = !reset && LongIssue_C && (!m_valid || m_done());
    nd   = fadr(0);
    @(posedge clk);
    cyc++;
    if (reset) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_t0    = cyc - 1;
      m_dest  = nd;
    end else if (m_valid && (cyc - m_t0) > LONG_LAT) m_valid = 1'b0;
    m_sel = nsel;
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; srcAdr_R = '0; srcUsed_R = '0; rdAdr_R = '0; RegWrite_R = 1'b0;
    LongReq_R = 1'b0; fwdAdr = '0; fwdWrite = '0; fwdLoad = '0; LongIssue_C = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_total++; if (FwdSel_C !== 4'd0) $display("FAIL reset_fwdsel got %0h exp 0", FwdSel_C); else n_pass++;
    n_total++; if (LongDone !== 1'b0) $display("FAIL reset_longdone got %0b exp 0", LongDone); else n_pass++;
    n_total++; if (LongBusy !== 1'b0) $display("FAIL reset_longbusy got %0b exp 0", LongBusy); else n_pass++;
    n_total++; if (StallPC !== 1'b0) $display("FAIL reset_stallpc got %0b exp 0", StallPC); else n_pass++;
    n_total++; if (FlushRC !== 1'b0) $display("FAIL reset_flushrc got %0b exp 0", FlushRC); else n_pass++;
  endtask

  task automatic test_forward();
    clear_inputs();
    fwdAdr = {5'd0, 5'd5}; fwdWrite = 2'b01; srcAdr_R = {5'd0, 5'd5}; srcUsed_R = 2'b01;
    #1;
    n_total++; if (StallPC !== 1'b0) $display("FAIL alu_no_stall got %0b exp 0", StallPC); else n_pass++;
    tick();
    n_total++; if (FwdSel_C[1:0] !== 2'd1) $display("FAIL alu_fwd_c got %0d exp 1", FwdSel_C[1:0]); else n_pass++;
    fwdAdr = {5'd5, 5'd5}; fwdWrite = 2'b11;
    tick();
    n_total++; if (FwdSel_C[1:0] !== 2'd1) $display("FAIL youngest_wins got %0d exp 1", FwdSel_C[1:0]); else n_pass++;
    fwdAdr = {5'd5, 5'd3};
    tick();
    n_total++; if (FwdSel_C[1:0] !== 2'd2) $display("FAIL fwd_from_m got %0d exp 2", FwdSel_C[1:0]); else n_pass++;
    fwdAdr = '0; srcAdr_R = '0; srcUsed_R = 2'b11;
    tick();
    n_total++; if (FwdSel_C !== 4'd0) $display("FAIL x0_no_fwd got %0h exp 0", FwdSel_C); else n_pass++;
  endtask

  task automatic test_load_use();
    clear_inputs();
    fwdAdr = {5'd0, 5'd7}; fwdWrite = 2'b01; fwdLoad = 2'b01;
    srcAdr_R = {5'd7, 5'd0}; srcUsed_R = 2'b10;
    #1;
    n_total++; if (StallPC !== 1'b1) $display("FAIL load_stallpc got %0b exp 1", StallPC); else n_pass++;
    n_total++; if (StallIR !== 1'b1) $display("FAIL load_stallir got %0b exp 1", StallIR); else n_pass++;
    n_total++; if (FlushRC !== 1'b1) $display("FAIL load_flushrc got %0b exp 1", FlushRC); else n_pass++;
    tick();
    n_total++; if (FwdSel_C !== 4'd0) $display("FAIL load_sel_forced got %0h exp 0", FwdSel_C); else n_pass++;
    fwdAdr = {5'd7, 5'd0}; fwdWrite = 2'b10; fwdLoad = 2'b10;
    #1;
    n_total++; if (StallPC !== 1'b0) $display("FAIL load_in_m_stall got %0b exp 0", StallPC); else n_pass++;
    tick();
    n_total++; if (FwdSel_C[3:2] !== 2'd2) $display("FAIL load_in_m_sel got %0d exp 2", FwdSel_C[3:2]); else n_pass++;
  endtask

  task automatic test_long_raw();
    int  stalls = 0;
    bit  done_seen = 1'b0;
    int  c = 1;
    clear_inputs();
    fwdAdr = {5'd0, 5'd9}; fwdWrite = 2'b01; LongIssue_C = 1'b1;
    tick();
    clear_inputs();
    srcAdr_R = {5'd0, 5'd9}; srcUsed_R = 2'b01;
    while (c <= LONG_LAT + 3 && !done_seen) begin
      #1;
      if (LongDone === 1'b1) begin
        done_seen = 1'b1;
        n_total++; if (c !== LONG_LAT) $display("FAIL div_done_cycle got %0d exp %0d", c, LONG_LAT); else n_pass++;
        n_total++; if (StallPC !== 1'b0) $display("FAIL div_done_no_stall got %0b exp 0", StallPC); else n_pass++;
      end else if (StallPC === 1'b1) stalls++;
      tick();
      c++;
    end
    n_total++; if (done_seen !== 1'b1) $display("FAIL div_done_seen got %0b exp 1", done_seen); else n_pass++;
    n_total++; if (stalls !== LONG_LAT - 1) $display("FAIL div_stall_cycles got %0d exp %0d", stalls, LONG_LAT - 1); else n_pass++;
    n_total++; if (FwdSel_C[1:0] !== 2'd3) $display("FAIL div_fwd_long got %0d exp 3", FwdSel_C[1:0]); else n_pass++;
    n_total++; if (LongBusy !== 1'b0) $display("FAIL div_busy_clear got %0b exp 0", LongBusy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    bit done_seen = 1'b0;
    int c = 0;
    clear_inputs();
    fwdAdr = {5'd0, 5'd10}; fwdWrite = 2'b01; LongIssue_C = 1'b1;
    tick();
    clear_inputs();
    LongReq_R = 1'b1;
    while (c < LONG_LAT + 3 && !done_seen) begin
      #1;
      if (LongDone === 1'b1) begin
        done_seen = 1'b1;
        n_total++; if (StallPC !== 1'b0) $display("FAIL struct_done_no_stall got %0b exp 0", StallPC); else n_pass++;
        fwdAdr = {5'd0, 5'd11}; fwdWrite = 2'b01; LongIssue_C = 1'b1;
      end else if (StallPC === 1'b1) stalls++;
      tick();
      c++;
    end
    n_total++; if (stalls !== LONG_LAT - 1) $display("FAIL struct_stall_cycles got %0d exp %0d", stalls, LONG_LAT - 1); else n_pass++;
    clear_inputs();
    #1;
    n_total++; if (LongBusy !== 1'b1) $display("FAIL reissue_busy got %0b exp 1", LongBusy); else n_pass++;
    n_total++; if (LongDone !== 1'b0) $display("FAIL reissue_done got %0b exp 0", LongDone); else n_pass++;
    srcAdr_R = {5'd0, 5'd11}; srcUsed_R = 2'b01;
    #1;
    n_total++; if (StallPC !== 1'b1) $display("FAIL reissue_raw got %0b exp 1", StallPC); else n_pass++;
    clear_inputs();
    repeat (LONG_LAT + 1) tick();
    n_total++; if (LongBusy !== 1'b0) $display("FAIL reissue_drain got %0b exp 0", LongBusy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit done_any = 1'b0;
    clear_inputs();
    fwdAdr = {5'd0, 5'd12}; fwdWrite = 2'b01; LongIssue_C = 1'b1;
    tick();
    clear_inputs();
    repeat (3) tick();
    n_total++; if (LongBusy !== 1'b1) $display("FAIL mid_busy_before got %0b exp 1", LongBusy); else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    srcAdr_R = {5'd0, 5'd12}; srcUsed_R = 2'b01;
    #1;
    n_total++; if (LongBusy !== 1'b0) $display("FAIL mid_busy_after got %0b exp 0", LongBusy); else n_pass++;
    n_total++; if (StallPC !== 1'b0) $display("FAIL mid_no_stall got %0b exp 0", StallPC); else n_pass++;
    repeat (LONG_LAT + 2) begin
      tick();
      if (LongDone !== 1'b0) done_any = 1'b1;
    end
    n_total++; if (done_any !== 1'b0) $display("FAIL mid_no_done got %0b exp 0", done_any); else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NUM_SRC; i++) srcAdr_R[i*ADR_W +: ADR_W] = ADR_W'($urandom_range(0, 3));
      for (int k = 0; k < NUM_FWD; k++) fwdAdr[k*ADR_W +: ADR_W] = ADR_W'($urandom_range(0, 3));
      srcUsed_R   = NUM_SRC'($urandom);
      fwdWrite    = NUM_FWD'($urandom);
      fwdLoad     = NUM_FWD'($urandom);
      rdAdr_R     = ADR_W'($urandom_range(0, 3));
      RegWrite_R  = 1'($urandom);
      LongReq_R   = ($urandom_range(0, 3) == 0);
      LongIssue_C = ($urandom_range(0, 5) == 0);
      #1;
      n_total++; if (FwdSel_C !== m_sel) $display("FAIL rnd_fwdsel cyc %0d got %0h exp %0h", cyc, FwdSel_C, m_sel); else n_pass++;
      n_total++; if (StallPC !== m_stall()) $display("FAIL rnd_stallpc cyc %0d got %0b exp %0b", cyc, StallPC, m_stall()); else n_pass++;
      n_total++; if (FlushRC !== m_stall()) $display("FAIL rnd_flushrc cyc %0d got %0b exp %0b", cyc, FlushRC, m_stall()); else n_pass++;
      n_total++; if (LongDone !== m_done()) $display("FAIL rnd_longdone cyc %0d got %0b exp %0b", cyc, LongDone, m_done()); else n_pass++;
      n_total++; if (LongBusy !== m_valid) $display("FAIL rnd_longbusy cyc %0d got %0b exp %0b", cyc, LongBusy, m_valid); else n_pass++;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_forward();
    test_load_use();
    test_long_raw();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
